// File: rtl/niosqsys_led_pwm_pkg.sv
// niosqsys_led_pwm_pkg: register map, reset values and CTRL field positions for the LED PWM block
package niosqsys_led_pwm_pkg;
  localparam logic [1:0] ADDR_DUTY = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;
  localparam logic [31:0] DUTY_RST = 32'hFFFF_FFFF;
  localparam int PERIOD_RST = 250;
  localparam logic [31:0] CTRL_RST = 32'h0000_0100;
  localparam logic [31:0] CTRL_MASK = 32'h0000_011F;
  localparam int CTRL_INV = 4;
  localparam int CTRL_EN = 8;
endpackage

// File: rtl/niosqsys_led_pwm_if.sv
// niosqsys_led_pwm_if: Avalon-MM slave bus carrying the LED PWM configuration accesses
interface niosqsys_led_pwm_if;
  logic [1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/niosqsys_led_pwm_timebase.sv
// niosqsys_led_pwm_timebase: prescaler, PWM frame counter and blink phase generator
module niosqsys_led_pwm_timebase #(
  parameter int PRESC_DIV = 195,
  parameter int PER_BITS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic [PER_BITS-1:0] period,
  input  logic restart,
  output logic [7:0] pwm_cnt,
  output logic frame_end,
  output logic blink_phase
);
  localparam int PW = PRESC_DIV > 1 ? $clog2(PRESC_DIV) : 1;
  logic [PW-1:0] r_presc;
  logic [7:0] r_pwm_cnt;
  logic [PER_BITS-1:0] r_blink_cnt;
  logic r_blink_phase;
  logic w_tick;
  logic w_wrap;
  logic [PER_BITS-1:0] w_limit;
  assign w_tick = r_presc == PW'(PRESC_DIV - 1);
  assign w_limit = period == '0 ? '0 : period - PER_BITS'(1);
  assign w_wrap = r_blink_cnt >= w_limit;
  assign pwm_cnt = r_pwm_cnt;
  assign frame_end = w_tick && r_pwm_cnt == 8'hFF;
  assign blink_phase = r_blink_phase;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_pwm_cnt <= '0;
      r_blink_cnt <= '0;
      r_blink_phase <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      r_pwm_cnt <= w_tick ? r_pwm_cnt + 8'd1 : r_pwm_cnt;
      if (restart) begin
        r_blink_cnt <= '0;
        r_blink_phase <= 1'b1;
      end else if (frame_end) begin
        r_blink_cnt <= w_wrap ? '0 : r_blink_cnt + PER_BITS'(1);
        r_blink_phase <= w_wrap ? ~r_blink_phase : r_blink_phase;
      end
    end
  end
endmodule

// File: rtl/niosqsys_led_pwm.sv
// niosqsys_led_pwm: Avalon-MM configured PWM brightness, blink and polarity stage for the LED PIO
module niosqsys_led_pwm
  import niosqsys_led_pwm_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int PRESC_DIV = 195,
  parameter int PER_BITS = 16
) (
  input  logic clk,
  input  logic reset,
  niosqsys_led_pwm_if.slave bus,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out
);
  logic [31:0] r_duty_shadow;
  logic [31:0] r_duty_active;
  logic [PER_BITS-1:0] r_period;
  logic [31:0] r_ctrl;
  logic [7:0] w_pwm_cnt;
  logic w_frame_end;
  logic w_blink_phase;
  logic w_wr;
  logic w_restart;
  logic [NUM_LEDS-1:0] w_raw;
  assign w_wr = bus.chipselect & ~bus.write_n;
  assign w_restart = w_wr && bus.address == ADDR_PERIOD;
  niosqsys_led_pwm_timebase #(.PRESC_DIV(PRESC_DIV), .PER_BITS(PER_BITS)) u_timebase (
    .clk(clk),
    .reset(reset),
    .period(r_period),
    .restart(w_restart),
    .pwm_cnt(w_pwm_cnt),
    .frame_end(w_frame_end),
    .blink_phase(w_blink_phase)
  );
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    logic [7:0] w_duty;
    assign w_duty = r_duty_active[8*i +: 8];
    assign w_raw[i] = r_ctrl[CTRL_EN] & led_in[i] & (w_duty == 8'hFF || w_pwm_cnt < w_duty) & (~r_ctrl[i] | w_blink_phase);
  end
  assign bus.readdata = bus.address == ADDR_DUTY ? r_duty_shadow :
                        bus.address == ADDR_PERIOD ? 32'(r_period) :
                        bus.address == ADDR_CTRL ? r_ctrl :
                        {16'h0, w_pwm_cnt, 3'b0, w_blink_phase, led_out};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty_shadow <= DUTY_RST;
      r_duty_active <= DUTY_RST;
      r_period <= PER_BITS'(PERIOD_RST);
      r_ctrl <= CTRL_RST;
      led_out <= '0;
    end else begin
      r_duty_shadow <= w_wr && bus.address == ADDR_DUTY ? bus.writedata : r_duty_shadow;
      r_period <= w_restart ? bus.writedata[PER_BITS-1:0] : r_period;
      r_ctrl <= w_wr && bus.address == ADDR_CTRL ? bus.writedata & CTRL_MASK : r_ctrl;
      r_duty_active <= w_frame_end ? r_duty_shadow : r_duty_active;
      led_out <= w_raw ^ {NUM_LEDS{r_ctrl[CTRL_INV]}};
    end
  end
endmodule

// File: tb/tb_niosqsys_led_pwm.sv
// tb_niosqsys_led_pwm: randomized scoreboard bench against a frame-level LED model
`timescale 1ns/1ps
module tb_niosqsys_led_pwm;
  localparam int PRESC = 2;
  localparam int FRAME = 256 * PRESC;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] led_in = 4'h0;
  logic [3:0] led_out;
  logic rd_chk = 1'b0;
  int checks = 0;
  int passed = 0;
  niosqsys_led_pwm_if bus();
  niosqsys_led_pwm #(.NUM_LEDS(4), .PRESC_DIV(PRESC), .PER_BITS(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .led_in(led_in),
    .led_out(led_out)
  );
  always #5 clk = ~clk;
  logic m_valid = 1'b0;
  int unsigned m_e;
  int unsigned m_fsr;
  logic [31:0] m_shadow;
  logic [31:0] m_active;
  logic [31:0] m_ctrl;
  logic [15:0] m_period;
  logic [3:0] m_led;
  logic [3:0] led_q[$];
  logic [31:0] rd_q[$];
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask
  always @(negedge clk) begin
    logic [7:0] pwm;
    logic [7:0] d;
    logic ph;
    logic [3:0] nxt;
    int unsigned p;
    if (reset) begin
      m_valid = 1'b1;
      m_e = 0;
      m_fsr = 0;
      m_shadow = 32'hFFFF_FFFF;
      m_active = 32'hFFFF_FFFF;
      m_period = 16'd250;
      m_ctrl = 32'h100;
      m_led = 4'h0;
      led_q.push_back(4'h0);
    end else if (m_valid) begin
      pwm = 8'((m_e / PRESC) % 256);
      p = m_period == 0 ? 1 : m_period;
      ph = ((m_fsr / p) % 2) == 0;
      if (rd_chk)
        rd_q.push_back(bus.address == 0 ? m_shadow : bus.address == 1 ? {16'h0, m_period} :
                       bus.address == 2 ? m_ctrl : {16'h0, pwm, 3'b0, ph, m_led});
      for (int i = 0; i < 4; i++) begin
        d = m_active[8*i +: 8];
        nxt[i] = m_ctrl[8] && led_in[i] && (d == 8'hFF || pwm < d) && (!m_ctrl[i] || ph);
      end
      nxt = nxt ^ {4{m_ctrl[4]}};
      led_q.push_back(nxt);
      if (m_e % FRAME == FRAME - 1) begin
        m_active = m_shadow;
        m_fsr++;
      end
      if (bus.chipselect && !bus.write_n) begin
        if (bus.address == 0) m_shadow = bus.writedata;
        if (bus.address == 1) begin
          m_period = bus.writedata[15:0];
          m_fsr = 0;
        end
        if (bus.address == 2) m_ctrl = bus.writedata & 32'h11F;
      end
      m_led = nxt;
      m_e++;
    end
  end
  always @(negedge clk) begin
    logic [31:0] e;
    #1;
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      check("readdata", bus.readdata, e);
    end
    if (led_q.size() >= 2) begin
      e = {28'h0, led_q.pop_front()};
      check("led_out", {28'h0, led_out}, e);
    end
  end
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(logic [1:0] a, logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    step();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask
  task automatic rd(logic [1:0] a);
    bus.address = a;
    rd_chk = 1'b1;
    step();
    rd_chk = 1'b0;
  endtask
  task automatic wait_pwm(logic [7:0] v, string name);
    logic ok;
    ok = 1'b0;
    bus.address = 2'd3;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      @(negedge clk);
      #2;
      ok = bus.readdata[15:8] == v;
    end
    if (!ok) begin
      checks++;
      $display("FAIL %s timeout waiting for pwm_cnt=%0d", name, v);
    end
  endtask
  initial begin
    int cnt;
    bus.address = 2'd0;
    bus.writedata = 32'h0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    step(2);
    reset = 1'b0;
    led_in = 4'b1010;
    step(3);
    rd(0);
    rd(1);
    rd(2);
    wr(0, 32'h0000_0080);
    led_in = 4'hF;
    step(1100);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      cnt += int'(led_out[0]);
      step();
    end
    check("led0_high_count", cnt, 256);
    wr(1, 32'd2);
    wr(2, 32'h101);
    led_in = 4'h1;
    for (int i = 0; i < 9; i++) begin
      step(470);
      rd(3);
    end
    wr(1, 32'd1);
    step(FRAME + 30);
    wait_pwm(8'd254, "pre_frame");
    wait_pwm(8'd255, "frame_edge");
    @(posedge clk);
    #1;
    wr(1, 32'd1);
    rd(3);
    rd(1);
    step(FRAME);
    rd(3);
    led_in = 4'b0110;
    wr(2, 32'h010);
    step(2);
    wr(2, 32'h110);
    step(3);
    rd(2);
    wait_pwm(8'd100, "mid_frame");
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(0);
    rd(1);
    rd(2);
    rd(3);
    repeat (300) begin
      case ($urandom_range(0, 12))
        0: wr(0, $urandom());
        1: wr(0, {4{8'(($urandom_range(0, 3) == 0) ? 8'hFF : ($urandom_range(0, 1) == 0 ? 8'h00 : 8'($urandom())))}});
        2: wr(1, {16'($urandom()), 16'($urandom_range(0, 3))});
        3: wr(2, $urandom());
        4: rd(2'($urandom_range(0, 3)));
        5: rd(2'd3);
        6: begin
          reset = 1'b1;
          step();
          reset = 1'b0;
        end
        default: begin
          led_in = 4'($urandom());
          step($urandom_range(1, 200));
        end
      endcase
    end
    step(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
